tile_fetch_arbiter: RTL and testbench
=====================================

# tile_fetch_arbiter

- Shares the single-port 1200-entry tile map RAM between the CPU and the VGA glyph path. The RAM holds 40x30 tiles of 16x16 pixels.
- At the start of horizontal blanking before each new tile row, it bursts the row's 40 tile indices into an internal line buffer. The glyph renderer reads that buffer combinationally during active video.
- All other RAM cycles go to the CPU through a req/ack handshake.
- The block sits between VGAControl timing outputs, the CPU memory port, and the tile RAM.

## Interface
Parameters:
- COLS, 40, tiles per row
- ROWS, 30, tiles per column
- ADDR_W, 11, tile RAM address width
- DATA_W, 8, tile index width

Ports:
- clk  in  1  system clock; the 50 MHz clock, not the pixel clock
- clear  in  1  reset; asynchronous, active-high
- hblank_start  in  1  one-clk pulse at the start of each horizontal blank
- next_line  in  10  active line displayed after this blank; ≥480 means none
- bright  in  1  active-video indicator from VGAControl, synchronous to clk
- col  in  6  tile column requested by the glyph renderer (0..39)
- tile_idx  out  DATA_W  linebuf[col], combinational; 0 when col ≥ 40
- cpu_req  in  1  CPU access request; held with addr, we and wdata until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  tile map address (0..1199)
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM with 1-cycle read latency
- busy  out  1  high while a burst is pending or running
- underrun  out  1  sticky error flag

## Operation
States:
- IDLE, CPU_ISSUE, CPU_WAIT, BURST, BURST_TAIL

Burst trigger:
- A burst is triggered by hblank_start with next_line < 480 and next_line[3:0] == 0.
- A trigger latches `pend`, with row = next_line[9:4].
- A trigger is ignored while pend is set or a burst is running.

IDLE arbitration:
- pend has priority: go to BURST with c = 0 and base = (row<<5) + (row<<3).
- Else cpu_req with cpu_ack low: go to CPU_ISSUE.
- cpu_ack high blocks a grant for that cycle, giving a turnaround cycle.

CPU_ISSUE (cycle G):
- mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
- Next state is CPU_WAIT.

CPU_WAIT (G+1):
- mem_we = 0.
- cpu_rdata <= mem_rdata for reads; unchanged for writes.
- cpu_ack <= 1; return to IDLE.
- cpu_ack is therefore high in G+2 for both reads and writes.

Burst:
- A CPU access already in CPU_ISSUE/CPU_WAIT completes before the burst starts. A burst never aborts a CPU access.
- BURST: mem_addr = base + c, mem_we = 0, for c = 0..39 on consecutive cycles.
- The RAM result for c is written into linebuf[c] one cycle later.
- After c = 39 the FSM goes to BURST_TAIL, which captures linebuf[39] and clears pend; then back to IDLE.
- CPU requests stall during a burst; cpu_ack is never issued in BURST or BURST_TAIL.

Underrun:
- A rising edge of bright while busy sets underrun. The burst still completes.
- underrun clears only on clear.

Arithmetic and range rules:
- Addresses are computed in ADDR_W bits; the maximum is 29*40 + 39 = 1199.
- cpu_addr ≥ 1200 is passed to the RAM unchecked.

## Timing
Reset (clear high, async):
- State IDLE, pend = 0.
- linebuf all 0; tile_idx = 0.
- cpu_ack = 0, cpu_rdata = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0, busy = 0, underrun = 0.
- clear asserted mid-burst or mid-CPU access abandons it. No ack is issued; the partial linebuf is zeroed.

Latencies:
- CPU access: grant to ack is 2 cycles. The minimum req-to-ack with an idle arbiter is 3 cycles (IDLE decision, G, G+1, ack in G+2 counted from the request edge).
- Burst: 41 cycles from entering BURST to return to IDLE. The worst case from hblank_start is 44 clks, which is well under one 320-clk hblank at a 25 MHz pixel rate.
- busy asserts the cycle after the trigger and deasserts the cycle after BURST_TAIL.

Simultaneous events:
- Trigger and cpu_req in the same cycle: the burst wins.
- Trigger during CPU_ISSUE: pend is held; the burst starts right after CPU_WAIT.
- A CPU write to row r during row r's burst is held until the burst ends. linebuf shows the old value until the next burst of row r.

## Test plan
- Reset, then CPU write 0x5A to address 85, then CPU read of 85 → cpu_ack 2 cycles after each grant; cpu_rdata = 0x5A with ack; mem_we high only in the write's G cycle.
- Preload RAM[40*k + c] = (k*7 + c) & 0xFF. Pulse hblank_start with next_line = 32 → 40 reads at addresses 80..119 on consecutive cycles; afterwards col = c gives tile_idx = 14 + c; busy high for exactly 41 cycles.
- hblank_start with next_line = 33, then with 480 → no burst, busy stays 0, linebuf unchanged.
- cpu_req and trigger in the same cycle (next_line = 0) → burst runs first on addresses 0..39; the CPU ack arrives 2 cycles after the burst ends; no ack during the burst.
- bright rises while busy → underrun = 1 and stays 1 through later idle frames; the burst still fills all 40 entries; clear → underrun = 0.
- clear asserted at burst cycle 20 → all outputs return to reset values within the same cycle; tile_idx = 0 for every col; the next trigger restarts a full burst at c = 0.

Source files
------------

// File: rtl/tile_fetch_arbiter.sv
// Tile map RAM arbiter: bursts one tile row into a line buffer at hblank and
// hands every other RAM cycle to the CPU through a req/ack handshake.
module tile_fetch_arbiter #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              hblank_start,
    input  logic [9:0]        next_line,
    input  logic              bright,
    input  logic [5:0]        col,
    output logic [DATA_W-1:0] tile_idx,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              underrun
);

    // state      | meaning
    // IDLE       | arbitration point; pending burst beats CPU request
    // CPU_ISSUE  | CPU address/data/we on the RAM port (cycle G)
    // CPU_WAIT   | RAM read data returns, ack registered for G+2
    // BURST      | read base+c from RAM, c = 0..COLS-1
    // BURST_TAIL | capture last linebuf entry, clear pend
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CPU_ISSUE  = 3'd1,
        CPU_WAIT   = 3'd2,
        BURST      = 3'd3,
        BURST_TAIL = 3'd4
    } state_t;

    localparam logic [9:0] LINES  = 10'(ROWS * 16);
    localparam logic [5:0] COLS_W = 6'(COLS);
    localparam logic [5:0] LAST_C = 6'(COLS - 1);

    state_t            state, state_d;
    logic              pend;
    logic [5:0]        row_q;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        c_q;
    logic              bright_q;
    logic [DATA_W-1:0] linebuf [COLS];

    logic              burst_run;
    logic              trig;
    logic [5:0]        row_sel;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] base_sel;

    assign burst_run = (state == BURST) || (state == BURST_TAIL);
    assign trig      = hblank_start && (next_line < LINES) && (next_line[3:0] == 4'd0)
                       && !pend && !burst_run;
    assign busy      = pend || burst_run;

    // A trigger seen in IDLE starts the burst immediately, before pend is visible.
    assign row_sel  = pend ? row_q : next_line[9:4];
    assign row_ext  = ADDR_W'(row_sel);
    assign base_sel = (row_ext << 5) + (row_ext << 3);

    always_comb begin
        state_d   = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (pend || trig)
                    state_d = BURST;
                else if (cpu_req && !cpu_ack)
                    state_d = CPU_ISSUE;
            end
            CPU_ISSUE: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                state_d   = CPU_WAIT;
            end
            CPU_WAIT: begin
                state_d = IDLE;
            end
            BURST: begin
                mem_addr = base_q + ADDR_W'(c_q);
                if (c_q == LAST_C)
                    state_d = BURST_TAIL;
            end
            BURST_TAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            pend      <= 1'b0;
            row_q     <= '0;
            base_q    <= '0;
            c_q       <= '0;
            bright_q  <= 1'b0;
            underrun  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            for (int i = 0; i < COLS; i++)
                linebuf[i] <= '0;
        end else begin
            state    <= state_d;
            bright_q <= bright;
            cpu_ack  <= (state == CPU_WAIT);
            if ((state == CPU_WAIT) && !cpu_we)
                cpu_rdata <= mem_rdata;
            if (trig) begin
                pend  <= 1'b1;
                row_q <= next_line[9:4];
            end
            if (bright && !bright_q && busy)
                underrun <= 1'b1;
            // RAM data lags the address by one cycle, so entry c lands while c+1 is issued.
            case (state)
                IDLE: begin
                    if (state_d == BURST) begin
                        base_q <= base_sel;
                        c_q    <= '0;
                    end
                end
                BURST: begin
                    c_q <= c_q + 6'd1;
                    if (c_q != 6'd0)
                        linebuf[c_q - 6'd1] <= mem_rdata;
                end
                BURST_TAIL: begin
                    linebuf[LAST_C] <= mem_rdata;
                    pend            <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tile_idx = '0;
        if (col < COLS_W)
            tile_idx = linebuf[col];
    end

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Scoreboard bench for tile_fetch_arbiter: a behavioural RAM/line-buffer model
// predicts CPU read data, burst addresses and tile_idx contents.
module tb_tile_fetch_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic        hblank_start;
    logic [9:0]  next_line;
    logic        bright;
    logic [5:0]  col;
    logic [7:0]  tile_idx;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        underrun;

    always #5 clk = ~clk;

    tile_fetch_arbiter #(.COLS(40), .ROWS(30), .ADDR_W(11), .DATA_W(8)) dut (
        .clk(clk), .clear(clear), .hblank_start(hblank_start), .next_line(next_line),
        .bright(bright), .col(col), .tile_idx(tile_idx),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .underrun(underrun)
    );

    logic [7:0]  ram     [0:2047];
    logic [7:0]  ref_ram [0:2047];
    logic [7:0]  exp_lb  [0:39];
    logic [7:0]  exp_q   [$];
    logic [7:0]  last_rd;
    int          checks = 0;
    int          errors = 0;
    int          we_cycles = 0;
    logic [10:0] we_addr;
    logic [7:0]  we_data;

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation; acks must never overlap a burst.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cycles++;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        if (cpu_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack with rdata %0h, expected no ack", cpu_rdata);
            end else begin
                chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
            end
            chk("ack_outside_busy", 32'(busy), 32'd0);
        end
    end

    task automatic check_linebuf(input string name);
        for (int i = 0; i < 64; i++) begin
            col = 6'(i);
            #1;
            chk(name, 32'(tile_idx), (i < 40) ? 32'(exp_lb[i]) : 32'd0);
        end
    endtask

    task automatic cpu_access(input bit we, input int addr, input logic [7:0] wd, output int lat);
        bit got;
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 11'(addr);
        cpu_wdata = wd;
        if (we) begin
            exp_q.push_back(last_rd);
            ref_ram[addr] = wd;
        end else begin
            last_rd = ref_ram[addr];
            exp_q.push_back(last_rd);
        end
        lat = 0;
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cpu_ack) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout: no ack after %0d cycles, expected an ack", lat);
        end
        cpu_req = 1'b0;
    endtask

    task automatic do_burst(input logic [9:0] line, input bit expect_b);
        int          base;
        int          cnt;
        int          bad;
        logic [10:0] addrs [$];
        @(posedge clk); #1;
        base = int'(line[9:4]) * 40;
        if (expect_b)
            for (int i = 0; i < 40; i++) exp_lb[i] = ref_ram[base + i];
        hblank_start = 1'b1;
        next_line    = line;
        @(posedge clk); #1;
        hblank_start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                addrs.push_back(mem_addr);
            end else if (cnt > 0 || t >= 6) begin
                break;
            end
        end
        chk("burst_busy_cycles", cnt, expect_b ? 32'd41 : 32'd0);
        if (expect_b) begin
            bad = 0;
            for (int i = 0; i < 40; i++)
                if (i >= addrs.size() || addrs[i] !== 11'(base + i)) bad++;
            chk("burst_addr_seq_bad", bad, 32'd0);
        end
        check_linebuf(expect_b ? "tile_idx_after_burst" : "tile_idx_unchanged");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          r;
        logic [9:0]  line;
        logic [7:0]  v;
        clear = 1'b1; hblank_start = 1'b0; next_line = '0; bright = 1'b0; col = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; last_rd = '0;
        for (int a = 0; a < 2048; a++) begin
            v = (a < 1200) ? 8'((a / 40) * 7 + (a % 40)) : 8'd0;
            ram[a]     = v;
            ref_ram[a] = v;
        end
        for (int i = 0; i < 40; i++) exp_lb[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        check_linebuf("rst_tile_idx");
        @(negedge clk) clear = 1'b0;

        // Directed CPU write then read of address 85.
        cpu_access(1, 85, 8'h5A, lat);
        chk("write_latency", lat, 3);
        chk("write_we_cycles", we_cycles, 1);
        chk("write_addr", 32'(we_addr), 85);
        chk("write_data", 32'(we_data), 32'h5A);
        cpu_access(0, 85, 8'h00, lat);
        chk("read_latency", lat, 3);
        chk("read_we_cycles", we_cycles, 1);

        // Row 2 burst, then the two non-trigger lines.
        do_burst(10'd32, 1);
        col = 6'd0;  #1; chk("row2_col0", 32'(tile_idx), 14);
        col = 6'd39; #1; chk("row2_col39", 32'(tile_idx), 53);
        do_burst(10'd33, 0);
        do_burst(10'd480, 0);

        // Trigger and CPU request in the same cycle: burst first.
        fork
            do_burst(10'd0, 1);
            begin
                int l2;
                cpu_access(0, 85, 8'h00, l2);
                chk("simul_ack_latency", l2, 45);
            end
        join

        // CPU write into the row being fetched is held until the burst ends.
        fork
            do_burst(10'd32, 1);
            begin
                int l3;
                repeat (5) @(posedge clk);
                cpu_access(1, 83, 8'hC3, l3);
                chk("held_write_latency", l3, 40);
            end
        join
        cpu_access(0, 83, 8'h00, lat);
        chk("readback_latency", lat, 3);

        // Underrun: bright rises mid-burst; sticky until clear.
        chk("underrun_before", 32'(underrun), 0);
        fork
            do_burst(10'd64, 1);
            begin
                repeat (10) @(posedge clk);
                #1 bright = 1'b1;
            end
        join
        chk("underrun_set", 32'(underrun), 1);
        bright = 1'b0;
        repeat (5) @(posedge clk);
        #1 bright = 1'b1;
        repeat (3) @(posedge clk);
        #1 bright = 1'b0;
        do_burst(10'd96, 1);
        chk("underrun_sticky", 32'(underrun), 1);
        @(negedge clk) clear = 1'b1;
        #1;
        chk("underrun_cleared", 32'(underrun), 0);
        for (int i = 0; i < 40; i++) exp_lb[i] = '0;
        last_rd = '0;
        @(negedge clk) clear = 1'b0;

        // Clear in the middle of a burst.
        do_burst(10'd128, 1);
        @(posedge clk); #1;
        hblank_start = 1'b1;
        next_line    = 10'd80;
        @(posedge clk); #1;
        hblank_start = 1'b0;
        repeat (20) @(posedge clk);
        #2 clear = 1'b1;
        #1;
        chk("midclr_busy", 32'(busy), 0);
        chk("midclr_mem_addr", 32'(mem_addr), 0);
        chk("midclr_mem_we", 32'(mem_we), 0);
        chk("midclr_cpu_ack", 32'(cpu_ack), 0);
        chk("midclr_cpu_rdata", 32'(cpu_rdata), 0);
        for (int i = 0; i < 40; i++) exp_lb[i] = '0;
        last_rd = '0;
        check_linebuf("midclr_tile_idx");
        @(negedge clk) clear = 1'b0;
        do_burst(10'd80, 1);

        // Randomized mix of CPU traffic and trigger attempts.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                cpu_access(1'($urandom_range(0, 1)), $urandom_range(0, 1199), 8'($urandom), lat);
                chk("rand_cpu_latency", lat, 3);
            end else if (r == 2) begin
                do_burst(10'($urandom_range(0, 29) * 16), 1);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    line = 10'($urandom_range(0, 29) * 16 + $urandom_range(1, 15));
                else
                    line = 10'($urandom_range(480, 1023));
                do_burst(line, 0);
            end
        end
        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
